mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single RAM port between instruction fetch (IF) and load/store (LS).
// Define MEM_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYC cycles.
module mem_port_arbiter #(
   parameter int unsigned MEM_BYTES     = 512,
   parameter int unsigned MAX_LS_STREAK = 4,
   parameter int unsigned TIMEOUT_CYC   = 16
) (
   input  logic        Clk,
   input  logic        Clr,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic        if_err,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_ack,
   output logic        ls_err,
   output logic [31:0] ls_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [5:0]  mem_op,
   output logic        mem_rw,
   output logic        mem_mov,
   input  logic        mem_moc,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        grant_ls
);

   typedef enum logic [2:0] {StIdle, StCheck, StSetup, StStrobe, StWait, StDone} state_e;

   localparam int unsigned StreakW = $clog2(MAX_LS_STREAK + 1);

   state_e             state_q, state_d;
   logic [StreakW-1:0] streak_q;
   logic               grant_ls_q, req_we_q, err_q, mem_rw_q;
   logic [1:0]         req_size_q;
   logic [31:0]        req_addr_q, req_wdata_q, mem_addr_q, mem_wdata_q;
   logic [31:0]        if_rdata_q, ls_rdata_q;
   logic [5:0]         mem_op_q;

   logic               pick_ls, legal, align_ok, range_ok, tmo_hit;
   logic [32:0]        nbytes, last_byte;
   logic [31:0]        rdata_sized;
   logic [5:0]         op_enc;

   // LS has priority unless it has already won MAX_LS_STREAK times in a row over a waiting IF.
   assign pick_ls = ls_req && (!if_req || (streak_q != StreakW'(MAX_LS_STREAK)));

   always_comb begin
      nbytes      = 33'd4;
      align_ok    = (req_addr_q[1:0] == 2'b00);
      rdata_sized = mem_rdata;
      case (req_size_q)
         2'b00: begin
            nbytes      = 33'd1;
            align_ok    = 1'b1;
            rdata_sized = {24'd0, mem_rdata[7:0]};
         end
         2'b01: begin
            nbytes      = 33'd2;
            align_ok    = ~req_addr_q[0];
            rdata_sized = {16'd0, mem_rdata[15:0]};
         end
         default: ;
      endcase
      last_byte = {1'b0, req_addr_q} + nbytes - 33'd1;
      range_ok  = (last_byte < 33'(MEM_BYTES));
      legal     = (req_size_q != 2'b11) && align_ok && range_ok;
      op_enc    = {2'b10, req_we_q, 1'b0,
                   (req_size_q == 2'b10) ? 2'b11 : {1'b0, (req_size_q == 2'b01)}};
   end

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
   logic [TmoW-1:0] tmo_q;

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         tmo_q <= '0;
      end else if (state_q == StCheck) begin
         tmo_q <= '0;
      end else if (state_q == StWait) begin
         tmo_q <= tmo_q + 1'b1;
      end
   end

   assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYC - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (if_req || ls_req) state_d = StCheck;
         StCheck:  state_d = legal ? StSetup : StDone;
         StSetup:  state_d = StStrobe;
         StStrobe: state_d = StWait;
         StWait:   if (mem_moc || tmo_hit) state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      mem_mov = (state_q == StStrobe) || (state_q == StWait);
      busy    = (state_q != StIdle);
      if_ack  = (state_q == StDone) && !grant_ls_q;
      ls_ack  = (state_q == StDone) && grant_ls_q;
      if_err  = if_ack && err_q;
      ls_err  = ls_ack && err_q;
   end

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         streak_q    <= '0;
         grant_ls_q  <= 1'b0;
         req_we_q    <= 1'b0;
         req_size_q  <= 2'b00;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         err_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_op_q    <= '0;
         mem_rw_q    <= 1'b1;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (!if_req || pick_ls) begin
                  streak_q <= (if_req && pick_ls) ? streak_q + 1'b1 : '0;
               end else begin
                  streak_q <= '0;
               end
               if (if_req || ls_req) begin
                  grant_ls_q  <= pick_ls;
                  req_we_q    <= pick_ls && ls_we;
                  req_size_q  <= pick_ls ? ls_size : 2'b10;
                  req_addr_q  <= pick_ls ? ls_addr : if_addr;
                  req_wdata_q <= pick_ls ? ls_wdata : 32'd0;
               end
            end
            StCheck: begin
               err_q <= !legal;
               if (legal) begin
                  mem_addr_q  <= req_addr_q;
                  mem_wdata_q <= req_wdata_q;
                  mem_op_q    <= op_enc;
                  mem_rw_q    <= !req_we_q;
               end else if (grant_ls_q) begin
                  ls_rdata_q <= '0;
               end
            end
            StWait: begin
               if (mem_moc) begin
                  if (grant_ls_q) ls_rdata_q <= rdata_sized;
                  else            if_rdata_q <= rdata_sized;
               end else if (tmo_hit) begin
                  err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_op    = mem_op_q;
   assign mem_rw    = mem_rw_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;
   assign grant_ls  = grant_ls_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-array RAM model answering MOV with MOC.
// The timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

   logic        Clk, Clr;
   logic        if_req, if_ack, if_err;
   logic [31:0] if_addr, if_rdata;
   logic        ls_req, ls_we, ls_ack, ls_err;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr, ls_wdata, ls_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [5:0]  mem_op;
   logic        mem_rw, mem_mov, mem_moc, busy, grant_ls;

   logic [7:0]  ram [0:511];
   logic        moc_en;

   int          n_chk, n_pass;
   int          lat_r, movcnt_r, ack_cnt;
   logic        err_r, gls_r, got_ack, mov_at_ack_r;
   logic [5:0]  op_r;
   logic [9:0]  exp_g;

   mem_port_arbiter dut (
      .Clk       (Clk),
      .Clr       (Clr),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_err    (if_err),
      .if_rdata  (if_rdata),
      .ls_req    (ls_req),
      .ls_we     (ls_we),
      .ls_size   (ls_size),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_ack    (ls_ack),
      .ls_err    (ls_err),
      .ls_rdata  (ls_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_op    (mem_op),
      .mem_rw    (mem_rw),
      .mem_mov   (mem_mov),
      .mem_moc   (mem_moc),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .grant_ls  (grant_ls)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // RAM model: acts on the first MOV cycle, raises MOC for the following cycle.
   always @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         mem_moc <= 1'b0;
      end else if (mem_mov && !mem_moc && moc_en) begin
         if (!mem_rw) begin
            case (mem_op[1:0])
               2'b00: ram[mem_addr[8:0]] <= mem_wdata[7:0];
               2'b01: begin
                  ram[mem_addr[8:0]]         <= mem_wdata[15:8];
                  ram[mem_addr[8:0] + 9'd1]  <= mem_wdata[7:0];
               end
               default: begin
                  ram[mem_addr[8:0]]         <= mem_wdata[31:24];
                  ram[mem_addr[8:0] + 9'd1]  <= mem_wdata[23:16];
                  ram[mem_addr[8:0] + 9'd2]  <= mem_wdata[15:8];
                  ram[mem_addr[8:0] + 9'd3]  <= mem_wdata[7:0];
               end
            endcase
         end else begin
            case (mem_op[1:0])
               2'b00:   mem_rdata <= {24'd0, ram[mem_addr[8:0]]};
               2'b01:   mem_rdata <= {16'd0, ram[mem_addr[8:0]], ram[mem_addr[8:0] + 9'd1]};
               default: mem_rdata <= {ram[mem_addr[8:0]], ram[mem_addr[8:0] + 9'd1],
                                      ram[mem_addr[8:0] + 9'd2], ram[mem_addr[8:0] + 9'd3]};
            endcase
         end
         mem_moc <= 1'b1;
      end else begin
         mem_moc <= 1'b0;
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Called with a request already raised while the DUT is in IDLE.
   task automatic run_txn();
      lat_r = 0; movcnt_r = 0; op_r = '0; got_ack = 1'b0;
      err_r = 1'b0; gls_r = 1'b0; mov_at_ack_r = 1'b0;
      for (int k = 1; k <= 40 && !got_ack; k++) begin
         tick();
         if (mem_mov) begin
            movcnt_r++;
            op_r = mem_op;
         end
         if (if_ack || ls_ack) begin
            got_ack      = 1'b1;
            lat_r        = k;
            err_r        = if_ack ? if_err : ls_err;
            gls_r        = ls_ack;
            mov_at_ack_r = mem_mov;
         end
      end
      chk("ack_seen", got_ack, 1'b1);
   endtask

   task automatic if_txn(input logic [31:0] addr);
      if_req = 1'b1; if_addr = addr;
      run_txn();
      if_req = 1'b0;
      tick();
   endtask

   task automatic ls_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
      ls_req = 1'b1; ls_we = we; ls_size = size; ls_addr = addr; ls_wdata = wdata;
      run_txn();
      ls_req = 1'b0;
      tick();
   endtask

   initial begin
      n_chk = 0; n_pass = 0; moc_en = 1'b1;
      Clr = 1'b1; if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_addr = '0; ls_wdata = '0;
      mem_rdata = '0;
      for (int i = 0; i < 512; i++) ram[i] <= 8'h00;
      ram[16] <= 8'h01; ram[17] <= 8'h02; ram[18] <= 8'h03; ram[19] <= 8'h04;
      ram[20] <= 8'h11; ram[21] <= 8'h22; ram[22] <= 8'h33; ram[23] <= 8'h44;
      ram[33] <= 8'h55; ram[34] <= 8'h66; ram[510] <= 8'hCD;

      repeat (2) tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_mov", mem_mov, 1'b0);
      chk("rst_rw", mem_rw, 1'b1);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_op", mem_op, 6'd0);
      chk("rst_acks", {if_ack, ls_ack, if_err, ls_err}, 4'd0);
      chk("rst_grant", grant_ls, 1'b0);
      chk("rst_rdata", if_rdata | ls_rdata, 32'd0);
      Clr = 1'b0;
      tick();

      // Plain fetch.
      if_txn(32'h10);
      chk("if_lat", lat_r, 5);
      chk("if_movcnt", movcnt_r, 2);
      chk("if_op", op_r, 6'b100011);
      chk("if_err", err_r, 1'b0);
      chk("if_rdata", if_rdata, 32'h01020304);
      chk("if_grant", grant_ls, 1'b0);

      // Misaligned half store is rejected without touching RAM.
      ls_txn(1'b1, 2'b01, 32'h21, 32'h1234);
      chk("mis_lat", lat_r, 2);
      chk("mis_err", err_r, 1'b1);
      chk("mis_mov", movcnt_r, 0);
      chk("mis_ram", {ram[33], ram[34]}, 16'h5566);
      chk("mis_grant", grant_ls, 1'b1);

      ls_txn(1'b1, 2'b00, 32'h1FF, 32'h000000AB);
      chk("sb_lat", lat_r, 5);
      chk("sb_err", err_r, 1'b0);
      chk("sb_op", op_r, 6'b101000);
      chk("sb_ram", ram[511], 8'hAB);

      ls_txn(1'b0, 2'b00, 32'h1FF, 32'h0);
      chk("lb_op", op_r, 6'b100000);
      chk("lb_err", err_r, 1'b0);
      chk("lb_rdata", ls_rdata, 32'h000000AB);

      ls_txn(1'b0, 2'b01, 32'h1FE, 32'h0);
      chk("lh_op", op_r, 6'b100001);
      chk("lh_rdata", ls_rdata, 32'h0000CDAB);

      ls_txn(1'b0, 2'b10, 32'h1FE, 32'h0);
      chk("lw_1fe_lat", lat_r, 2);
      chk("lw_1fe_err", err_r, 1'b1);
      chk("lw_1fe_rdata", ls_rdata, 32'd0);

      ls_txn(1'b0, 2'b10, 32'h200, 32'h0);
      chk("lw_200_err", err_r, 1'b1);
      ls_txn(1'b0, 2'b11, 32'h0, 32'h0);
      chk("size11_err", err_r, 1'b1);
      ls_txn(1'b1, 2'b10, 32'h1FC, 32'hDEADBEEF);
      chk("sw_1fc_op", op_r, 6'b101011);
      chk("sw_1fc_ram", {ram[508], ram[509], ram[510], ram[511]}, 32'hDEADBEEF);
      chk("if_rdata_hold", if_rdata, 32'h01020304);

      // Both requesters held: IF forced in after four LS wins, streak restarts.
      exp_g = 10'b0111101111;
      if_req = 1'b1; if_addr = 32'h10;
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h14;
      for (int i = 0; i < 10; i++) begin
         run_txn();
         chk($sformatf("arb_ack%0d", i), gls_r, exp_g[i]);
         chk($sformatf("arb_grant%0d", i), grant_ls, exp_g[i]);
      end
      chk("arb_ls_rdata", ls_rdata, 32'h11223344);
      if_req = 1'b0; ls_req = 1'b0;
      tick();

      // Reset in WAIT kills the transaction immediately.
      moc_en = 1'b0;
      if_req = 1'b1; if_addr = 32'h14;
      repeat (4) tick();
      chk("clr_pre_mov", mem_mov, 1'b1);
      #2 Clr = 1'b1;
      #1;
      chk("clr_mov", mem_mov, 1'b0);
      chk("clr_busy", busy, 1'b0);
      if_req = 1'b0;
      tick();
      Clr = 1'b0; moc_en = 1'b1; ack_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (if_ack || ls_ack) ack_cnt++;
      end
      chk("clr_no_ack", ack_cnt, 0);
      if_txn(32'h10);
      chk("post_clr_lat", lat_r, 5);
      chk("post_clr_rdata", if_rdata, 32'h01020304);

`ifdef MEM_TIMEOUT_EN
      moc_en = 1'b0;
      if_txn(32'h14);
      chk("tmo_lat", lat_r, 20);
      chk("tmo_err", err_r, 1'b1);
      chk("tmo_mov_done", mov_at_ack_r, 1'b0);
      chk("tmo_rdata", if_rdata, 32'h01020304);
      moc_en = 1'b1;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
